// File: rtl/arb_pkg.sv
// Shared definitions for the 8-port arbiter and its requester-side agent.
package arb_pkg;

    localparam int NUM_PORTS = 8;
    localparam int PORT_W    = 3;
    localparam int LEN_W     = 4;

    // Agent FSM: wait for grant, run beats, release grant, wait for arbiter to drop valid
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } agent_state_t;

    // One-hot decode of a port index
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] p);
        return NUM_PORTS'(1) << p;
    endfunction

endpackage

// File: rtl/arb_pending_vec.sv
// Per-port pending-request register vector. A set and a clear on the same
// port in the same cycle leaves the bit set, so a fresh request is queued.
module arb_pending_vec
    import arb_pkg::*;
#(
    parameter int N = NUM_PORTS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] set_i,
    input  logic [N-1:0] clr_i,
    output logic [N-1:0] pend_o
);

    logic [N-1:0] pend_q;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            // Set has priority over clear for each port bit
            always_ff @(posedge clk) begin
                if (reset) begin
                    pend_q[gi] <= 1'b0;
                end else if (set_i[gi]) begin
                    pend_q[gi] <= 1'b1;
                end else if (clr_i[gi]) begin
                    pend_q[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign pend_o = pend_q;

endmodule

// File: rtl/arb_port_agent.sv
// Requester-side agent: queues client requests towards the arbiter, runs a
// fixed-length transfer window per accepted grant, then returns the grant.
module arb_port_agent
    import arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] client_req,
    input  logic [LEN_W-1:0]     cfg_burst_len,
    input  logic [PORT_W-1:0]    gnt_port,
    input  logic                 gnt_valid,
    output logic [NUM_PORTS-1:0] port_req,
    output logic                 gnt_ack,
    output logic [PORT_W-1:0]    ack_port,
    output logic [NUM_PORTS-1:0] client_busy,
    output logic [NUM_PORTS-1:0] client_done,
    output logic                 spurious_gnt
);

    agent_state_t         state_q, state_d;
    logic [PORT_W-1:0]    cur_port_q, cur_port_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [PORT_W-1:0]    ack_port_q, ack_port_d;
    logic                 spurious_q, spurious_d;
    logic [NUM_PORTS-1:0] clr_vec;
    logic                 grant_seen;
    logic                 accept;

    // A grant is only considered while idle; it is accepted only if that port is pending
    assign grant_seen = (state_q == ST_IDLE) && gnt_valid;
    assign accept     = grant_seen && port_req[gnt_port];

    arb_pending_vec #(.N(NUM_PORTS)) u_pending (
        .clk    (clk),
        .reset  (reset),
        .set_i  (client_req),
        .clr_i  (clr_vec),
        .pend_o (port_req)
    );

    // State register plus transfer context (port, beat counter, last acked port, sticky flag)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_port_q <= '0;
            cnt_q      <= '0;
            ack_port_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_port_q <= cur_port_d;
            cnt_q      <= cnt_d;
            ack_port_q <= ack_port_d;
            spurious_q <= spurious_d;
        end
    end

    // Next-state logic; the counter is loaded with at least 1 and stops at 1
    always_comb begin
        state_d    = state_q;
        cur_port_d = cur_port_q;
        cnt_d      = cnt_q;
        ack_port_d = ack_port_q;
        spurious_d = spurious_q | (grant_seen && !port_req[gnt_port]);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cur_port_d = gnt_port;
                    cnt_d      = (cfg_burst_len == '0) ? LEN_W'(1) : cfg_burst_len;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (cnt_q <= LEN_W'(1)) begin
                    ack_port_d = cur_port_q;
                    state_d    = ST_ACK;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!gnt_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state and transfer context
    always_comb begin
        client_busy = '0;
        client_done = '0;
        gnt_ack     = 1'b0;
        clr_vec     = accept ? port_onehot(gnt_port) : '0;
        case (state_q)
            ST_XFER: begin
                client_busy = port_onehot(cur_port_q);
                if (cnt_q <= LEN_W'(1)) begin
                    client_done = port_onehot(cur_port_q);
                end
            end
            ST_ACK: begin
                gnt_ack = 1'b1;
            end
            default: begin
                gnt_ack = 1'b0;
            end
        endcase
    end

    assign ack_port     = ack_port_q;
    assign spurious_gnt = spurious_q;

endmodule

// File: tb/tb_arb_port_agent.sv
// Self-checking bench for arb_port_agent. A pending-bit model and a
// transaction-level timeline (L busy beats, done on the last, ack next) give
// the expected values.
module tb_arb_port_agent;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] client_req;
    logic [3:0] cfg_burst_len;
    logic [2:0] gnt_port;
    logic       gnt_valid;
    logic [7:0] port_req;
    logic       gnt_ack;
    logic [2:0] ack_port;
    logic [7:0] client_busy;
    logic [7:0] client_done;
    logic       spurious_gnt;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_pend;
    logic       m_spur;

    arb_port_agent dut (
        .clk           (clk),
        .reset         (reset),
        .client_req    (client_req),
        .cfg_burst_len (cfg_burst_len),
        .gnt_port      (gnt_port),
        .gnt_valid     (gnt_valid),
        .port_req      (port_req),
        .gnt_ack       (gnt_ack),
        .ack_port      (ack_port),
        .client_busy   (client_busy),
        .client_done   (client_done),
        .spurious_gnt  (spurious_gnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request pulse, then compare the pending vector
    task automatic pulse(input logic [7:0] req);
        client_req = req;
        tick();
        client_req = '0;
        m_pend = m_pend | req;
        checks++;
        if (port_req !== m_pend) begin
            errors++;
            $display("FAIL pulse_port_req got %h want %h", port_req, m_pend);
        end
    endtask

    // Offer a grant while the agent is idle and follow the whole transaction
    task automatic run_grant(input logic [2:0] p, input logic [3:0] len,
                             input logic [7:0] req_acc, input bit rand_req, input int hold);
        bit         exp_acc;
        int         eff;
        logic [7:0] pb;
        logic [7:0] rq;
        exp_acc = m_pend[p];
        eff = (len == 0) ? 1 : int'(len);
        pb = 8'h01 << p;
        gnt_port = p;
        gnt_valid = 1'b1;
        cfg_burst_len = len;
        client_req = req_acc;
        tick();
        client_req = '0;
        $display("grant port %0d len %0d pending %h accept %0d", p, len, m_pend, exp_acc);
        if (exp_acc) m_pend = (m_pend & ~pb) | req_acc;
        else begin
            m_pend = m_pend | req_acc;
            m_spur = 1'b1;
        end
        if (!exp_acc) begin
            checks++;
            if (client_busy !== 8'h00 || gnt_ack !== 1'b0) begin
                errors++;
                $display("FAIL spur_no_xfer busy %h ack %b want 00 0", client_busy, gnt_ack);
            end
            checks++;
            if (spurious_gnt !== m_spur) begin
                errors++;
                $display("FAIL spur_flag got %b want %b", spurious_gnt, m_spur);
            end
            checks++;
            if (port_req !== m_pend) begin
                errors++;
                $display("FAIL spur_port_req got %h want %h", port_req, m_pend);
            end
            gnt_valid = 1'b0;
            tick();
            return;
        end
        // burst length must be captured at acceptance only
        cfg_burst_len = 4'($urandom_range(0, 15));
        for (int beat = 1; beat <= eff; beat++) begin
            checks++;
            if (client_busy !== pb || gnt_ack !== 1'b0) begin
                errors++;
                $display("FAIL xfer_busy beat %0d busy %h ack %b want %h 0", beat, client_busy, gnt_ack, pb);
            end
            checks++;
            if (client_done !== ((beat == eff) ? pb : 8'h00)) begin
                errors++;
                $display("FAIL xfer_done beat %0d got %h want %h", beat, client_done, (beat == eff) ? pb : 8'h00);
            end
            checks++;
            if (port_req !== m_pend) begin
                errors++;
                $display("FAIL xfer_port_req got %h want %h", port_req, m_pend);
            end
            rq = rand_req ? 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)) : 8'h00;
            client_req = rq;
            tick();
            client_req = '0;
            m_pend = m_pend | rq;
        end
        checks++;
        if (gnt_ack !== 1'b1 || ack_port !== p) begin
            errors++;
            $display("FAIL ack_pulse ack %b port %0d want 1 %0d", gnt_ack, ack_port, p);
        end
        checks++;
        if (client_busy !== 8'h00 || client_done !== 8'h00) begin
            errors++;
            $display("FAIL ack_idle busy %h done %h want 00 00", client_busy, client_done);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (gnt_ack !== 1'b0 || client_busy !== 8'h00 || port_req !== m_pend) begin
                errors++;
                $display("FAIL hold_valid ack %b busy %h req %h want 0 00 %h", gnt_ack, client_busy, port_req, m_pend);
            end
        end
        gnt_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (gnt_ack !== 1'b0 || ack_port !== p || port_req !== m_pend) begin
            errors++;
            $display("FAIL release ack %b port %0d req %h want 0 %0d %h", gnt_ack, ack_port, port_req, p, m_pend);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        client_req = '0;
        cfg_burst_len = '0;
        gnt_port = '0;
        gnt_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m_pend = '0;
        m_spur = 1'b0;
        checks++;
        if ({port_req, gnt_ack, ack_port, client_busy, client_done, spurious_gnt} !== '0) begin
            errors++;
            $display("FAIL reset_vals req %h ack %b port %0d busy %h done %h spur %b want all 0",
                     port_req, gnt_ack, ack_port, client_busy, client_done, spurious_gnt);
        end
    endtask

    task automatic test_single();
        pulse(8'b0001_0000);
        run_grant(3'd4, 4'd3, 8'h00, 1'b0, 0);
    endtask

    task automatic test_two_ports();
        pulse(8'b1000_0001);
        run_grant(3'd7, 4'd0, 8'h00, 1'b0, 0);
        run_grant(3'd0, 4'd0, 8'h00, 1'b0, 0);
        checks++;
        if (port_req !== 8'h00) begin
            errors++;
            $display("FAIL two_ports_final got %h want 00", port_req);
        end
    endtask

    task automatic test_spurious();
        run_grant(3'd2, 4'd2, 8'h00, 1'b0, 0);
        tick();
        checks++;
        if (spurious_gnt !== 1'b1 || client_busy !== 8'h00) begin
            errors++;
            $display("FAIL spur_sticky spur %b busy %h want 1 00", spurious_gnt, client_busy);
        end
    endtask

    task automatic test_set_wins_and_hold();
        pulse(8'b0001_0000);
        run_grant(3'd4, 4'd3, 8'b0001_0000, 1'b0, 3);
        checks++;
        if (port_req[4] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins got %b want 1", port_req[4]);
        end
        run_grant(3'd4, 4'd2, 8'h00, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        pulse(8'b0010_1000);
        gnt_port = 3'd3;
        gnt_valid = 1'b1;
        cfg_burst_len = 4'd4;
        tick();
        tick();
        checks++;
        if (client_busy !== 8'h08) begin
            errors++;
            $display("FAIL mid_beat2 busy %h want 08", client_busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        gnt_valid = 1'b0;
        m_pend = '0;
        m_spur = 1'b0;
        checks++;
        if ({port_req, gnt_ack, ack_port, client_busy, client_done, spurious_gnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset req %h ack %b port %0d busy %h done %h spur %b want all 0",
                     port_req, gnt_ack, ack_port, client_busy, client_done, spurious_gnt);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gnt_ack !== 1'b0 || client_busy !== 8'h00) begin
                errors++;
                $display("FAIL mid_no_ack cyc %0d ack %b busy %h want 0 00", i, gnt_ack, client_busy);
            end
        end
        pulse(8'b0000_0100);
        run_grant(3'd2, 4'd1, 8'h00, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [2:0] p;
        logic [7:0] r;
        for (int n = 0; n < 40; n++) begin
            r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            pulse(r);
            p = 3'($urandom_range(0, 7));
            if (m_pend != 8'h00 && $urandom_range(0, 9) < 8) begin
                while (!m_pend[p]) p = p + 3'd1;
            end
            run_grant(p, 4'($urandom_range(0, 6)), 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
                      1'b1, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_ports();
        test_spurious();
        test_set_wins_and_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
